// File: rtl/enc8b10b_pkg.sv
// Shared constants, legal control-code check and scheduler state type for the
// 8b/10b transmit path.
package enc8b10b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;

  localparam int N_LEGAL_K = 12;
  localparam logic [N_LEGAL_K-1:0][7:0] LEGAL_K = {
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
    8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  typedef enum logic [1:0] {OFF, ALIGN, DATA, SKIP} tx_sched_state_t;

  function automatic logic is_legal_k(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LEGAL_K; i++) begin
      if (b == LEGAL_K[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/enc8b10b_tx_sched_prbs7.sv
// PRBS7 (x^7+x^6+1) byte source; prbs_byte holds the next 8 generated bits,
// newest in bit 0, so its low 7 bits equal the LFSR state after 8 steps.
module enc8b10b_prbs7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed,
  input  logic       adv,
  output logic [7:0] prbs_byte
);

  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] walk;
  logic       fb;

  always_comb begin
    walk      = lfsr_q;
    prbs_byte = '0;
    fb        = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb        = walk[6] ^ walk[5];
      walk      = {walk[5:0], fb};
      prbs_byte = {prbs_byte[6:0], fb};
    end
    lfsr_d = lfsr_q;
    if (seed)     lfsr_d = 7'h7F;
    else if (adv) lfsr_d = walk;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 7'h7F;
    else      lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/enc8b10b_tx_sched.sv
// Transmit symbol scheduler in front of the 8b/10b encoder: comma alignment,
// user data with K28.5 idle fill, periodic K28.0 skip bursts, K-code policing.
// Optional PRBS7 data source when ENC_TX_PRBS_EN is defined (adds prbs_mode).
module enc8b10b_tx_sched
  import enc8b10b_pkg::*;
#(
  parameter int ALIGN_LEN   = 16,
  parameter int SKIP_PERIOD = 1024,
  parameter int SKIP_LEN    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic [7:0] s_data,
  input  logic       s_k,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       aligned,
  output logic       err_k
`ifdef ENC_TX_PRBS_EN
  ,
  input  logic       prbs_mode
`endif
);

  localparam logic [7:0]  ALIGN_LAST = 8'(ALIGN_LEN - 1);
  localparam logic [15:0] SKIP_LAST  = 16'(SKIP_PERIOD - 1);
  localparam logic [3:0]  BURST_LAST = 4'(SKIP_LEN - 1);

  tx_sched_state_t state_q, state_d;
  logic [7:0]  align_cnt_q, align_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [7:0]  enc_data_q, enc_data_d;
  logic        enc_k_q, enc_k_d;
  logic        enc_valid_q, enc_valid_d;
  logic        aligned_q, aligned_d;
  logic        err_k_q, err_k_d;
  logic        load;

`ifdef ENC_TX_PRBS_EN
  logic       prbs_seed, prbs_adv;
  logic [7:0] prbs_byte;

  enc8b10b_prbs7 u_prbs7 (
    .clk       (clk),
    .rst       (rst),
    .seed      (prbs_seed),
    .adv       (prbs_adv),
    .prbs_byte (prbs_byte)
  );
`endif

  always_comb begin
    load        = !enc_valid_q || enc_ready;
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    burst_cnt_d = burst_cnt_q;
    enc_data_d  = enc_data_q;
    enc_k_d     = enc_k_q;
    enc_valid_d = enc_valid_q;
    aligned_d   = aligned_q;
    err_k_d     = err_k_q;
    s_ready     = 1'b0;
`ifdef ENC_TX_PRBS_EN
    prbs_seed   = 1'b0;
    prbs_adv    = 1'b0;
`endif
    // Nothing moves without a load, so a stalled symbol always completes first.
    if (load) begin
      if (state_q != OFF && !link_en) begin
        state_d     = OFF;
        enc_valid_d = 1'b0;
        aligned_d   = 1'b0;
      end else begin
        case (state_q)
          OFF: begin
            enc_valid_d = 1'b0;
            aligned_d   = 1'b0;
            if (link_en) begin
              state_d     = ALIGN;
              align_cnt_d = '0;
              err_k_d     = 1'b0;
`ifdef ENC_TX_PRBS_EN
              prbs_seed   = 1'b1;
`endif
            end
          end
          ALIGN: begin
            enc_data_d  = K28_5;
            enc_k_d     = 1'b1;
            enc_valid_d = 1'b1;
            aligned_d   = 1'b0;
            align_cnt_d = align_cnt_q + 8'd1;
            if (align_cnt_q == ALIGN_LAST) begin
              state_d    = DATA;
              skip_cnt_d = '0;
            end
          end
          DATA: begin
            enc_data_d  = K28_5;
            enc_k_d     = 1'b1;
            enc_valid_d = 1'b1;
            aligned_d   = 1'b1;
            skip_cnt_d  = skip_cnt_q + 16'd1;
            if (skip_cnt_q == SKIP_LAST) begin
              state_d     = SKIP;
              burst_cnt_d = '0;
            end
`ifdef ENC_TX_PRBS_EN
            if (prbs_mode) begin
              enc_data_d = prbs_byte;
              enc_k_d    = 1'b0;
              prbs_adv   = 1'b1;
            end else
`endif
            begin
              s_ready = 1'b1;
              if (s_valid) begin
                if (s_k && !is_legal_k(s_data)) begin
                  err_k_d = 1'b1;
                end else begin
                  enc_data_d = s_data;
                  enc_k_d    = s_k;
                end
              end
            end
          end
          SKIP: begin
            enc_data_d  = K28_0;
            enc_k_d     = 1'b1;
            enc_valid_d = 1'b1;
            aligned_d   = 1'b1;
            burst_cnt_d = burst_cnt_q + 4'd1;
            if (burst_cnt_q == BURST_LAST) begin
              state_d    = DATA;
              skip_cnt_d = '0;
            end
          end
          default: state_d = OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= OFF;
      align_cnt_q <= '0;
      skip_cnt_q  <= '0;
      burst_cnt_q <= '0;
      enc_data_q  <= '0;
      enc_k_q     <= 1'b0;
      enc_valid_q <= 1'b0;
      aligned_q   <= 1'b0;
      err_k_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      enc_data_q  <= enc_data_d;
      enc_k_q     <= enc_k_d;
      enc_valid_q <= enc_valid_d;
      aligned_q   <= aligned_d;
      err_k_q     <= err_k_d;
    end
  end

  assign enc_data  = enc_data_q;
  assign enc_k     = enc_k_q;
  assign enc_valid = enc_valid_q;
  assign aligned   = aligned_q;
  assign err_k     = err_k_q;

endmodule

// File: tb/tb_enc8b10b_tx_sched.sv
// Directed bench for enc8b10b_tx_sched: a default-parameter instance (a) and a
// short-period instance (b) share stimulus; checks observe one selected instance.
module tb_enc8b10b_tx_sched;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] SK = 8'h1C;

  logic       clk = 1'b0;
  logic       rst, link_en, s_k, s_valid, enc_ready;
  logic [7:0] s_data;
  logic       a_s_ready, a_enc_k, a_enc_valid, a_aligned, a_err_k;
  logic [7:0] a_enc_data;
  logic       b_s_ready, b_enc_k, b_enc_valid, b_aligned, b_err_k;
  logic [7:0] b_enc_data;
  logic       use_b;
  logic       o_rdy, o_k, o_valid, o_aligned, o_err;
  logic [7:0] o_data;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  enc8b10b_tx_sched dut_a (
    .clk(clk), .rst(rst), .link_en(link_en), .s_data(s_data), .s_k(s_k),
    .s_valid(s_valid), .s_ready(a_s_ready), .enc_data(a_enc_data), .enc_k(a_enc_k),
    .enc_valid(a_enc_valid), .enc_ready(enc_ready), .aligned(a_aligned), .err_k(a_err_k)
  );

  enc8b10b_tx_sched #(.ALIGN_LEN(4), .SKIP_PERIOD(8), .SKIP_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .link_en(link_en), .s_data(s_data), .s_k(s_k),
    .s_valid(s_valid), .s_ready(b_s_ready), .enc_data(b_enc_data), .enc_k(b_enc_k),
    .enc_valid(b_enc_valid), .enc_ready(enc_ready), .aligned(b_aligned), .err_k(b_err_k)
  );

  assign o_rdy     = use_b ? b_s_ready   : a_s_ready;
  assign o_data    = use_b ? b_enc_data  : a_enc_data;
  assign o_k       = use_b ? b_enc_k     : a_enc_k;
  assign o_valid   = use_b ? b_enc_valid : a_enc_valid;
  assign o_aligned = use_b ? b_aligned   : a_aligned;
  assign o_err     = use_b ? b_err_k     : a_err_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enable edge in OFF, then n K28.5 with aligned low, then aligned idle.
  task automatic expect_align(input int n);
    #1 chk("off_s_ready", 32'(o_rdy), 32'd0);
    tick();
    chk("enable_edge_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("align_sym", 32'({o_valid, o_data, o_k, o_aligned}), 32'({1'b1, BC, 1'b1, 1'b0}));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_sym", 32'({o_valid, o_data, o_k, o_aligned}), 32'({1'b1, BC, 1'b1, 1'b1}));
    end
  endtask

  // Instance b streaming: 4 align, 8 data, 2 skip, 8 data.
  task automatic run_stream(input logic [7:0] base);
    logic       rdy, ek, er;
    logic [7:0] ed;
    #1 chk("stream_off_rdy", 32'(o_rdy), 32'd0);
    tick();
    chk("stream_enable_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 22; i++) begin
      if (i < 4)       begin ed = BC;                 ek = 1'b1; er = 1'b0; end
      else if (i < 12) begin ed = base + 8'(i - 4);  ek = 1'b0; er = 1'b1; end
      else if (i < 14) begin ed = SK;                 ek = 1'b1; er = 1'b0; end
      else             begin ed = base + 8'(i - 6);  ek = 1'b0; er = 1'b1; end
      #1 chk("stream_s_ready", 32'(o_rdy), 32'(er));
      rdy = o_rdy;
      tick();
      chk("stream_sym", 32'({o_valid, o_data, o_k}), 32'({1'b1, ed, ek}));
      if (rdy) s_data = s_data + 8'd1;
    end
  endtask

  initial begin
    rst = 1'b0; link_en = 1'b0; s_k = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    enc_ready = 1'b1; use_b = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("reset_outputs", 32'({o_rdy, o_data, o_k, o_valid, o_aligned, o_err}), 32'd0);

    // Full 16-symbol align burst, then idle fill
    rst = 1'b1; link_en = 1'b1;
    expect_align(16);
    #1 chk("idle_s_ready", 32'(o_rdy), 32'd1);

    // Backpressure: A5 held stable, next byte one cycle after release
    s_valid = 1'b1; s_data = 8'h11;
    tick();
    chk("data_11", 32'({o_valid, o_data, o_k}), 32'({1'b1, 8'h11, 1'b0}));
    s_data = 8'hA5;
    tick();
    chk("data_a5", 32'({o_valid, o_data, o_k}), 32'({1'b1, 8'hA5, 1'b0}));
    enc_ready = 1'b0; s_data = 8'hA6;
    repeat (5) begin
      #1 chk("stall_s_ready", 32'(o_rdy), 32'd0);
      tick();
      chk("stall_hold_a5", 32'({o_valid, o_data}), 32'({1'b1, 8'hA5}));
    end
    enc_ready = 1'b1;
    #1 chk("release_s_ready", 32'(o_rdy), 32'd1);
    tick();
    chk("after_stall_a6", 32'({o_valid, o_data, o_k}), 32'({1'b1, 8'hA6, 1'b0}));

    // K policing
    s_k = 1'b1; s_data = 8'h3C;
    tick();
    chk("legal_k_3c", 32'({o_data, o_k, o_err}), 32'({8'h3C, 1'b1, 1'b0}));
    s_data = 8'h55;
    tick();
    chk("illegal_k_55", 32'({o_data, o_k, o_err}), 32'({BC, 1'b1, 1'b1}));
    s_k = 1'b0; s_data = 8'h22;
    tick();
    chk("data_after_err", 32'({o_data, o_k, o_err}), 32'({8'h22, 1'b0, 1'b1}));
    s_valid = 1'b0;
    tick();
    chk("err_sticky_idle", 32'({o_data, o_k, o_err}), 32'({BC, 1'b1, 1'b1}));

    // link_en falls while 7E is stalled
    s_valid = 1'b1; s_data = 8'h7E;
    tick();
    chk("data_7e", 32'({o_valid, o_data}), 32'({1'b1, 8'h7E}));
    enc_ready = 1'b0; link_en = 1'b0; s_valid = 1'b0;
    #1 chk("drop_s_ready", 32'(o_rdy), 32'd0);
    repeat (3) begin
      tick();
      chk("hold_7e", 32'({o_valid, o_data}), 32'({1'b1, 8'h7E}));
    end
    enc_ready = 1'b1;
    tick();
    chk("off_after_delivery", 32'({o_valid, o_aligned}), 32'd0);
    tick();
    chk("stay_off", 32'({o_valid, o_aligned, o_err}), 32'({1'b0, 1'b0, 1'b1}));
    link_en = 1'b1;
    expect_align(16);
    chk("err_cleared_on_align", 32'(o_err), 32'd0);

    // Short-period instance: streaming with skip insertion
    use_b = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1; link_en = 1'b1; s_valid = 1'b1; s_k = 1'b0; s_data = 8'h00;
    run_stream(8'h00);
    tick();
    chk("skip_burst_start", 32'({o_valid, o_data, o_k}), 32'({1'b1, SK, 1'b1}));

    // Reset mid-skip burst clears outputs immediately
    rst = 1'b0;
    #1 chk("async_reset_clear", 32'({o_rdy, o_data, o_k, o_valid, o_aligned, o_err}), 32'd0);
    rst = 1'b1;
    run_stream(s_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
